// File: rtl/rc5_key_expand.sv
// RC5-16 key schedule: expands a 128-bit key into the S table (t = 2*(r+1) words) for a round engine.
// Latency: ready rises 1 + t + 3*max(t,8) cycles after the accepting edge; s_data is a combinational read.
// Backpressure: none; start is only accepted in IDLE/DONE, ignored while busy. Optional macro RC5_KEY_ZEROIZE_EN.
module rc5_key_expand #(
  parameter int W    = 16,
  parameter int TMAX = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [4:0]     num_rounds,
  input  logic [127:0]   key,
  output logic           busy,
  output logic           ready,
  input  logic [5:0]     s_addr,
  output logic [W-1:0]   s_data
);

  localparam int AW = $clog2(TMAX);  // S-table index width
  localparam int TW = AW + 1;        // holds t up to TMAX inclusive
  localparam int RW = $clog2(W);     // rotation amount width
  localparam logic [W-1:0] P16 = 16'hB7E1;
  localparam logic [W-1:0] Q16 = 16'h9E37;

  typedef enum logic [2:0] {IDLE, LOAD, INIT, MIX, DONE} state_t;

  state_t          state, state_nxt;
  logic [127:0]    key_q;
  logic [4:0]      rnd_q;
  logic [TW-1:0]   t_q;
  logic [7:0]      cnt;
  logic [W-1:0]    a_q, b_q, init_val;
  logic [AW-1:0]   i_q;
  logic [2:0]      j_q;
  logic [W-1:0]    s_mem [TMAX];
  logic [W-1:0]    l_mem [8];

  logic            accept, init_last, mix_last;
  logic [TW-1:0]   t_mix;
  logic [7:0]      mix_len;
  logic [W-1:0]    a_sum, a_new, ab, b_sum, b_new;
  logic [AW-1:0]   i_nxt;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] s);
    logic [2*W-1:0] d;
    d = {x, x} << s;
    return d[2*W-1:W];
  endfunction

  assign accept    = start && (state == IDLE || state == DONE);
  assign init_last = (cnt == ({1'b0, t_q} - 8'd1));
  // MIX runs 3*max(t,8) iterations; x*3 formed as x + 2x
  assign t_mix     = (t_q > TW'(8)) ? t_q : TW'(8);
  assign mix_len   = {1'b0, t_mix} + {t_mix, 1'b0};
  assign mix_last  = (cnt == (mix_len - 8'd1));
  assign i_nxt     = (({1'b0, i_q} + TW'(1)) == t_q) ? '0 : i_q + AW'(1);

  // One mixing iteration: A from S[i], then B from L[j] using the fresh A
  always_comb begin
    a_sum = s_mem[i_q] + a_q + b_q;
    a_new = rotl(a_sum, RW'(3));
    ab    = a_new + b_q;
    b_sum = l_mem[j_q] + ab;
    b_new = rotl(b_sum, ab[RW-1:0]);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state sequencing: LOAD is one cycle, INIT t cycles, MIX 3*max(t,8) cycles
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = INIT;
      INIT:    if (init_last) state_nxt = MIX;
      MIX:     if (mix_last) state_nxt = DONE;
      DONE:    if (accept) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot key and round count so later input changes cannot disturb a run
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      rnd_q <= '0;
    end else if (accept) begin
      key_q <= key;
      rnd_q <= num_rounds;
    end
  end

  // Control and A/B/i/j datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q      <= '0;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      init_val <= '0;
    end else begin
      case (state)
        LOAD: begin
          t_q      <= {1'b0, rnd_q, 1'b0} + TW'(2);
          cnt      <= '0;
          a_q      <= '0;
          b_q      <= '0;
          i_q      <= '0;
          j_q      <= '0;
          init_val <= P16;
        end
        INIT: begin
          init_val <= init_val + Q16;
          cnt      <= init_last ? 8'd0 : cnt + 8'd1;
        end
        MIX: begin
          a_q <= a_new;
          b_q <= b_new;
          i_q <= i_nxt;
          j_q <= j_q + 3'd1;
          cnt <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // S and L storage writes; the last MIX edge optionally scrubs L
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state)
        LOAD: for (int k = 0; k < 8; k++) l_mem[k] <= key_q[16*k +: 16];
        INIT: s_mem[cnt[AW-1:0]] <= init_val;
        MIX: begin
          s_mem[i_q] <= a_new;
          l_mem[j_q] <= b_new;
`ifdef RC5_KEY_ZEROIZE_EN
          if (mix_last) for (int k = 0; k < 8; k++) l_mem[k] <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state == LOAD) || (state == INIT) || (state == MIX);
  assign ready = (state == DONE);

  // Table read port: entries beyond t read as zero
  always_comb begin
    s_data = '0;
    if ({1'b0, s_addr} < t_q) s_data = s_mem[s_addr];
`ifdef RC5_KEY_ZEROIZE_EN
    if (!ready) s_data = '0;
`endif
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Self-checking bench for rc5_key_expand: RC5-16 key schedule model, latency and control checks.
// Clock period 10; inputs driven 1 time unit after the rising edge, outputs sampled before the next edge.
// Honours RC5_KEY_ZEROIZE_EN when defined for the build.
module tb_rc5_key_expand;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [4:0]   num_rounds;
  logic [127:0] key;
  logic         busy, ready;
  logic [5:0]   s_addr;
  logic [15:0]  s_data;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 0;
  bit tbl_chk = 0;

  logic [15:0] m_s   [64];
  logic [15:0] exp_s [64];
  logic [15:0] part_s[64];

  rc5_key_expand #(.W(16), .TMAX(64)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rounds(num_rounds), .key(key),
    .busy(busy), .ready(ready), .s_addr(s_addr), .s_data(s_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rotl_m(input logic [15:0] x, input int s);
    logic [15:0] hi, lo;
    hi = x << s;
    lo = x >> (16 - s);
    return hi | lo;
  endfunction

  // Plain RC5-16 key schedule; n_iter < 0 means the full 3*max(t,8) mixing passes
  task automatic model(input logic [127:0] k, input int r, input int n_iter);
    logic [15:0] l [8];
    logic [15:0] a, b, tmp;
    int t, i, j, iters, sh;
    t = 2 * (r + 1);
    for (int n = 0; n < 64; n++)
      m_s[n] = (n < t) ? 16'hB7E1 + 16'(n * 32'h9E37) : 16'h0000;
    for (int n = 0; n < 8; n++) l[n] = k[16*n +: 16];
    a = 0; b = 0; i = 0; j = 0;
    iters = 3 * ((t > 8) ? t : 8);
    if (n_iter >= 0) iters = n_iter;
    for (int n = 0; n < iters; n++) begin
      tmp = m_s[i] + a + b;
      a = rotl_m(tmp, 3);
      m_s[i] = a;
      tmp = a + b;
      sh = int'(tmp) % 16;
      tmp = l[j] + a + b;
      b = rotl_m(tmp, sh);
      l[j] = b;
      i = (i + 1) % t;
      j = (j + 1) % 8;
    end
  endtask

  // Continuous checks: busy/ready exclusive, table contents whenever ready
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy_ready_excl", {31'b0, busy & ready}, 32'd0);
      if (tbl_chk && ready) chk("s_data_done", {16'b0, s_data}, {16'b0, exp_s[s_addr]});
`ifdef RC5_KEY_ZEROIZE_EN
      if (busy) chk("s_data_zero_busy", {16'b0, s_data}, 32'd0);
`endif
    end
  end

  task automatic run(input logic [127:0] k, input logic [4:0] r, input int glitch_at,
                     input bit probe, input int reset_at);
    int t, lat, cnt;
    bit got;
    logic [15:0] pexp;
    tbl_chk = 0;
    t   = 2 * (int'(r) + 1);
    lat = 1 + t + 3 * ((t > 8) ? t : 8);
    model(k, int'(r), -1);
    for (int n = 0; n < 64; n++) exp_s[n] = m_s[n];
    if (probe) begin
      model(k, int'(r), 10);
      for (int n = 0; n < 64; n++) part_s[n] = m_s[n];
    end
    @(posedge clk); #1;
    key = k; num_rounds = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    num_rounds = 5'($urandom_range(0, 31));
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("ready_drop_after_start", {31'b0, ready}, 32'd0);
    cnt = 0; got = 0;
    while (!got && cnt < 400) begin
      @(posedge clk); cnt++; #1;
      start = 1'b0;
      if (cnt == reset_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("busy_after_rst", {31'b0, busy}, 32'd0);
        chk("ready_after_rst", {31'b0, ready}, 32'd0);
        s_addr = 6'd7; #1;
        chk("s_data_after_rst", {16'b0, s_data}, 32'd0);
        return;
      end
      if (cnt == glitch_at) begin
        start = 1'b1; key = ~k; num_rounds = 5'd3;
      end
      if (probe && cnt == 1 + t + 10) begin
`ifdef RC5_KEY_ZEROIZE_EN
        pexp = 16'h0000;
`else
        pexp = part_s[20];
`endif
        s_addr = 6'd20; #1;
        chk("mix_probe_unmixed", {16'b0, s_data}, {16'b0, pexp});
`ifndef RC5_KEY_ZEROIZE_EN
        pexp = part_s[3];
`endif
        s_addr = 6'd3; #1;
        chk("mix_probe_mixed", {16'b0, s_data}, {16'b0, pexp});
      end
      if (ready) got = 1;
    end
    chk("latency", 32'(cnt), 32'(lat));
    if (got) begin
      tbl_chk = 1;
      for (int a = 0; a < 64; a++) begin
        @(posedge clk); #1;
        s_addr = 6'(a); #1;
        chk("table_sweep", {16'b0, s_data}, {16'b0, exp_s[a]});
      end
      chk("ready_hold", {31'b0, ready}, 32'd1);
`ifdef RC5_KEY_ZEROIZE_EN
      for (int n = 0; n < 8; n++) chk("l_scrubbed", {16'b0, dut.l_mem[n]}, 32'd0);
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Model pins against hand-computed values
    chk("pin_rotl", {16'b0, rotl_m(16'h8001, 1)}, 32'h0003);
    model(128'd0, 0, 0);
    chk("pin_init_s1", {16'b0, m_s[1]}, 32'h5618);
    model(128'd0, 31, 0);
    chk("pin_init_s63", {16'b0, m_s[63]}, 32'hA76A);
    model(128'd0, 0, 1);
    chk("pin_first_mix", {16'b0, m_s[0]}, 32'hBF0D);

    // Reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; key = '0; num_rounds = 5'd12; s_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    start = 1'b0; #1;
    chk("rst_s_data", {16'b0, s_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", {31'b0, busy}, 32'd0);
    mon_en = 1;

    run(128'd0, 5'd12, -1, 1'b1, -1);
    run(128'h0F0E0D0C0B0A09080706050403020100, 5'd0, -1, 1'b0, -1);
    run({$urandom, $urandom, $urandom, $urandom}, 5'd31, -1, 1'b0, -1);
    run({$urandom, $urandom, $urandom, $urandom}, 5'd12, 40, 1'b0, -1);
    run({$urandom, $urandom, $urandom, $urandom}, 5'd12, -1, 1'b0, 60);
    run({$urandom, $urandom, $urandom, $urandom}, 5'd12, -1, 1'b0, -1);
    for (int n = 0; n < 3; n++)
      run({$urandom, $urandom, $urandom, $urandom}, 5'($urandom_range(0, 31)), -1, 1'b0, -1);

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
